// File: rtl/bt_update_queue_pkg.sv
// Shared types and core configuration for the branch-target update queue.
//   bt_update_t      : one BTB training update (valid qualifies the entry)
//   BTU_QUEUE_DEPTH  : queue depth used by the core configuration
package bt_update_queue_pkg;

  localparam int BTU_QUEUE_DEPTH = 4;
  localparam int BTU_NUM_IN      = 2;
  localparam int BTU_DROP_CNT_W  = 8;

  typedef struct packed {
    logic        valid;
    logic [31:0] src;
    logic [31:0] dst;
    logic        is_call;
    logic        is_ret;
  } bt_update_t;

endpackage

// File: rtl/bt_update_queue_if.sv
// Handshake bundle between the ALU branch-resolution side, the queue and the BTB.
//   IN_clear      : flush the queue
//   IN_btUpdates  : NUM_IN per-ALU updates
//   IN_ready      : BTB accepts OUT_btUpdate this cycle
//   OUT_btUpdate  : queue head, valid = queue non-empty
//   OUT_dropCnt   : saturating count of dropped updates
// master = producer/consumer environment, slave = the queue.
interface bt_update_queue_if
  import bt_update_queue_pkg::*;
#(
  parameter int NUM_IN     = BTU_NUM_IN,
  parameter int DROP_CNT_W = BTU_DROP_CNT_W
);
  logic                         IN_clear;
  bt_update_t [NUM_IN-1:0]      IN_btUpdates;
  logic                         IN_ready;
  bt_update_t                   OUT_btUpdate;
  logic [DROP_CNT_W-1:0]        OUT_dropCnt;

  modport master (
    output IN_clear, IN_btUpdates, IN_ready,
    input  OUT_btUpdate, OUT_dropCnt
  );

  modport slave (
    input  IN_clear, IN_btUpdates, IN_ready,
    output OUT_btUpdate, OUT_dropCnt
  );
endinterface

// File: rtl/bt_update_compact.sv
// Combinational same-cycle dedupe and compaction of the per-ALU updates.
//   in_upd    : NUM_IN raw updates
//   keep_mask : bit i set when input i is valid and no valid lower port has its src
//   comp      : survivors packed toward index 0 in ascending port order
//   n_surv    : number of survivors
module bt_update_compact
  import bt_update_queue_pkg::*;
#(
  parameter int NUM_IN = BTU_NUM_IN,
  parameter int SW     = $clog2(NUM_IN + 1)
) (
  input  bt_update_t [NUM_IN-1:0] in_upd,
  output logic       [NUM_IN-1:0] keep_mask,
  output bt_update_t [NUM_IN-1:0] comp,
  output logic       [SW-1:0]     n_surv
);

  always_comb begin : p_compact
    int pos;
    pos       = 0;
    keep_mask = '0;
    comp      = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      keep_mask[i] = in_upd[i].valid;
      for (int j = 0; j < i; j++)
        if (in_upd[j].valid && (in_upd[j].src == in_upd[i].src)) keep_mask[i] = 1'b0;
    end
    // Slot of survivor i is the number of survivors below it.
    for (int i = 0; i < NUM_IN; i++) begin
      if (keep_mask[i]) begin
        for (int k = 0; k < NUM_IN; k++)
          if (k == pos) comp[k] = in_upd[i];
        pos = pos + 1;
      end
    end
    n_surv = SW'(pos);
  end

endmodule

// File: rtl/bt_update_queue.sv
// Circular queue of BTB training updates, drained one per cycle to the BTB.
// Never back-pressures the ALUs: updates that do not fit are dropped and counted.
//   clk, rst : clock, synchronous active-low reset
//   io       : bt_update_queue_if slave (see interface header)
module bt_update_queue
  import bt_update_queue_pkg::*;
#(
  parameter int NUM_IN     = BTU_NUM_IN,
  parameter int DEPTH      = BTU_QUEUE_DEPTH,
  parameter int DROP_CNT_W = BTU_DROP_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  bt_update_queue_if.slave io
);

  localparam int AW  = $clog2(DEPTH);
  localparam int CW  = AW + 1;
  localparam int SW  = $clog2(NUM_IN + 1);
  localparam int DSW = DROP_CNT_W + CW;
  localparam logic [DROP_CNT_W-1:0] DROP_MAX = {DROP_CNT_W{1'b1}};

  logic [AW-1:0]         rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic [DROP_CNT_W-1:0] drop_cnt_q, drop_cnt_d;
  bt_update_t            mem_q [DEPTH];
  bt_update_t            mem_d [DEPTH];

  logic       [NUM_IN-1:0] keep_mask;
  bt_update_t [NUM_IN-1:0] comp;
  logic       [SW-1:0]     n_surv;

  logic          deq;
  logic [CW-1:0] free_slots, surv, enq_n, drop_n;
  logic [DSW-1:0] drop_sum;

  bt_update_compact #(.NUM_IN(NUM_IN), .SW(SW)) u_compact (
    .in_upd    (io.IN_btUpdates),
    .keep_mask (keep_mask),
    .comp      (comp),
    .n_surv    (n_surv)
  );

  always_comb begin
    deq        = (count_q != '0) && io.IN_ready;
    // Free space is taken before this cycle's dequeue.
    free_slots = CW'(DEPTH) - count_q;
    surv       = CW'(n_surv);
    enq_n      = (surv < free_slots) ? surv : free_slots;
    drop_n     = surv - enq_n;
    drop_sum   = DSW'(drop_cnt_q) + DSW'(drop_n);

    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    drop_cnt_d = drop_cnt_q;
    mem_d      = mem_q;

    if (io.IN_clear) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      // Pointer arithmetic wraps modulo DEPTH, so a write may span DEPTH-1 -> 0.
      for (int k = 0; k < NUM_IN; k++)
        if (CW'(k) < enq_n) mem_d[wr_ptr_q + AW'(k)] = comp[k];
      wr_ptr_d   = wr_ptr_q + AW'(enq_n);
      rd_ptr_d   = rd_ptr_q + AW'(deq);
      count_d    = count_q + enq_n - CW'(deq);
      drop_cnt_d = (drop_sum > DSW'(DROP_MAX)) ? DROP_MAX : drop_sum[DROP_CNT_W-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      drop_cnt_q <= '0;
    end else begin
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  // Payload storage carries no reset; validity comes from count_q alone.
  always_ff @(posedge clk) mem_q <= mem_d;

  always_comb begin
    io.OUT_btUpdate       = mem_q[rd_ptr_q];
    io.OUT_btUpdate.valid = (count_q != '0);
  end
  assign io.OUT_dropCnt = drop_cnt_q;

  // Survivor count must agree with the dedupe mask.
  a_surv_cnt: assert property (@(posedge clk) disable iff (!rst)
    n_surv == SW'($countones(keep_mask)));

endmodule
